// File: rtl/vga_scan_output.sv
// VGA raster counters plus DAC/sync output stage. Sync and blanking ride a
// PIPE_LAT-deep delay line so they line up with colour returning from the drawers.
module vga_scan_output #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [3:0]  Red_level,
    input  logic [3:0]  Green_level,
    input  logic [3:0]  Blue_level,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        pixel_valid,
    output logic        start_of_frame,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    typedef struct packed {
        logic act;
        logic hs_n;
        logic vs_n;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    logic [10:0] hcnt, vcnt;
    logic        h_last, v_last;
    ctl_t        ctl_now, ctl_dly;

    assign h_last = (hcnt == 11'(H_TOTAL - 1));
    assign v_last = (vcnt == 11'(V_TOTAL - 1));

    // start_of_frame is registered off the wrap condition, so it is high
    // exactly while the counters sit at (0,0) after a full frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hcnt           <= '0;
            vcnt           <= '0;
            start_of_frame <= 1'b0;
        end else begin
            start_of_frame <= h_last && v_last;
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? 11'd0 : vcnt + 11'd1;
            end else begin
                hcnt <= hcnt + 11'd1;
            end
        end
    end

    assign pixelX      = hcnt;
    assign pixelY      = vcnt;
    assign pixel_valid = (hcnt < 11'(H_ACTIVE)) && (vcnt < 11'(V_ACTIVE));

    always_comb begin
        ctl_now      = CTL_IDLE;
        ctl_now.act  = pixel_valid;
        ctl_now.hs_n = !((hcnt >= 11'(HS_START)) && (hcnt < 11'(HS_END)));
        ctl_now.vs_n = !((vcnt >= 11'(VS_START)) && (vcnt < 11'(VS_END)));
    end

    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign ctl_dly = ctl_now;
        end else begin : g_pipe
            ctl_t [PIPE_LAT-1:0] ctl_pipe;

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    for (int i = 0; i < PIPE_LAT; i++) ctl_pipe[i] <= CTL_IDLE;
                end else begin
                    ctl_pipe[0] <= ctl_now;
                    for (int i = 1; i < PIPE_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
                end
            end

            assign ctl_dly = ctl_pipe[PIPE_LAT-1];
        end
    endgenerate

    // Colour is gated by the delayed blanking so nothing leaks onto the DAC
    // outside the visible window, whatever the drawers return.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            VGA_R  <= 4'h0;
            VGA_G  <= 4'h0;
            VGA_B  <= 4'h0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else begin
            VGA_R  <= ctl_dly.act ? Red_level   : 4'h0;
            VGA_G  <= ctl_dly.act ? Green_level : 4'h0;
            VGA_B  <= ctl_dly.act ? Blue_level  : 4'h0;
            VGA_HS <= ctl_dly.hs_n;
            VGA_VS <= ctl_dly.vs_n;
        end
    end

endmodule

// File: doc/vga_scan_output.md
# vga_scan_output

Scan generator and DAC driver at the display end of the pixel path. Runs the horizontal and vertical raster counters and issues pixel coordinates to the object drawers. It receives the prioritised 4-bit colour levels back from the drawing-priority stage after a fixed pipeline latency. It then drives the VGA R/G/B and sync pins, with sync and blanking delayed to stay aligned with the returning colour.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_LAT, 1, clocks from pixelX/pixelY issue to matching Red/Green/Blue_level arrival; range 0..7
- clk  in  1  pixel clock (25 MHz at defaults); all logic on rising edge
- resetN  in  1  asynchronous, active-low reset
- Red_level  in  4  prioritised red for pixel issued PIPE_LAT clocks earlier
- Green_level  in  4  as above, green
- Blue_level  in  4  as above, blue
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- pixel_valid  out  1  1 when pixelX<H_ACTIVE and pixelY<V_ACTIVE
- start_of_frame  out  1  one-clock pulse on frame wrap
- VGA_R, VGA_G, VGA_B  out  4 each  DAC levels
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low

## Operation
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525). Counters are 11-bit unsigned.
- hcnt increments every clock.
  - At H_TOTAL-1 it wraps to 0 and vcnt advances.
  - vcnt at V_TOTAL-1 wraps to 0 on the same edge.
- pixelX=hcnt, pixelY=vcnt, driven directly from the counter registers; pixel_valid is decoded combinationally from them.
- start_of_frame is a registered signal. It is 1 for exactly the clock in which the counters read (0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1).
  - No pulse follows reset release; the first pulse arrives one full frame later.
- Decode from counters:
  - act = pixel_valid
  - hs_n = 0 when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
  - vs_n = 0 when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC
  - vs_n is decoded on vcnt only (whole lines, not pixel-offset).
- {act, hs_n, vs_n} pass through a PIPE_LAT-deep shift register, then into the output register.
  - PIPE_LAT=0 means the output register only.
- Output register:
  - VGA_R/G/B = delayed act ? input levels : 4'h0
  - VGA_HS/VS = delayed hs_n/vs_n
- Colour inputs are ignored whenever delayed act is 0. The block never forwards a non-zero level during blanking.
- Reset (asynchronous):
  - hcnt=vcnt=0; start_of_frame=0
  - delay pipeline cleared to act=0, hs_n=1, vs_n=1
  - VGA_R/G/B=0, VGA_HS=VGA_VS=1
  - pixelX=pixelY=0 and pixel_valid=1 during reset (counter-derived).
- Reset mid-frame: all of the above take effect immediately. After release, the raster restarts at (0,0) on the first clock; no partial-line recovery.

## Timing
- Counter at cycle n produces VGA_HS/VS/blanking at cycle n+PIPE_LAT+1.
- Colour input sampled at cycle n+PIPE_LAT is driven on VGA_R/G/B at cycle n+PIPE_LAT+1. Total pixel latency from coordinate to pin is PIPE_LAT+1.
- At defaults (PIPE_LAT=1, one stage in drawing priority): coordinate (x,y) appears on the pins 2 clocks later.
- HS low for exactly H_SYNC clocks per line.
- VS low for exactly V_SYNC×H_TOTAL clocks per frame. Both sync edges on VGA_VS coincide with a pixel column 0 position (delayed by the same latency).
- Frame period is exactly H_TOTAL×V_TOTAL = 420000 clocks at defaults.

## Test plan
- Reset: hold resetN=0 with random colour inputs. Required: VGA_R/G/B=0, HS=VS=1, pixelX=pixelY=0, start_of_frame=0. Release: pixelX=1 on the next clock.
- Line timing at defaults: measure VGA_HS. Required: falls 656+2 clocks after pixelX=0 of the line, stays low 96 clocks, line period 800 clocks.
- Frame timing: required start_of_frame pulse every 420000 clocks. VGA_VS low for 1600 clocks starting when delayed vcnt=490.
- Alignment at PIPE_LAT=1: bench returns Red_level=pixelX[3:0] registered one clock. Required: VGA_R equals x[3:0] of each visible pixel in order. VGA_R=0 for x≥640 and y≥480 even with inputs forced to 4'hF.
- PIPE_LAT=3 build: same pattern with a 3-clock bench delay. Required: correct alignment, and HS falls at 656+4 clocks.
- Mid-frame reset at (x=300, y=200): outputs return to reset values asynchronously. After release the raster restarts at (0,0). The next start_of_frame arrives exactly 420000 clocks later.
